change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_pkg.sv | 30 +++
 rtl/change_dispenser_if.sv | 28 ++
 rtl/change_dispenser_coin_selector.sv | 24 ++
 rtl/change_dispenser.sv | 77 +++++++
 tb/tb_change_dispenser.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: money width, coin table and FSM encoding.
// Coin index 2 is the largest denomination; the selector relies on ascending order.
package change_dispenser_pkg;

    localparam int kTotalBits = 31;
    localparam int kNumCoins  = 3;

    typedef logic [kTotalBits-1:0] money_t;
    typedef logic [kNumCoins-1:0]  coin_mask_t;

    localparam money_t kCoinValue [kNumCoins] = '{money_t'(100), money_t'(500), money_t'(1000)};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Value of a one-hot coin selection; zero when nothing is selected.
    function automatic money_t coin_value(input coin_mask_t sel);
        money_t v;
        v = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (sel[i]) v = v | kCoinValue[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/coin bus between a requester (master) and the change dispenser (slave).
// Coin handshake: a coin transfers on a cycle where coin_valid && coin_ready; coin_sel is stable while coin_valid waits.
interface change_dispenser_if;
    import change_dispenser_pkg::*;

    logic       return_req;
    money_t     return_amount;
    coin_mask_t coin_empty;
    logic       coin_ready;
    logic       coin_valid;
    coin_mask_t coin_sel;
    logic       busy;
    logic       done;
    logic       short;
    money_t     remainder;
    logic [7:0] coins_out;

    modport master (
        output return_req, return_amount, coin_empty, coin_ready,
        input  coin_valid, coin_sel, busy, done, short, remainder, coins_out
    );

    modport slave (
        input  return_req, return_amount, coin_empty, coin_ready,
        output coin_valid, coin_sel, busy, done, short, remainder, coins_out
    );

endinterface

// File: rtl/change_dispenser_coin_selector.sv
// Priority selector: picks the largest available coin not exceeding the remaining balance.
module coin_selector
    import change_dispenser_pkg::*;
(
    input  money_t     remainder,
    input  coin_mask_t coin_empty,
    output coin_mask_t sel,
    output logic       found
);

    // Ascending scan so a later (larger) eligible coin overrides smaller ones.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (!coin_empty[i] && (kCoinValue[i] <= remainder)) begin
                sel    = '0;
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested balance one coin at a time, largest available first.
// Reports completion with done, and short when a residue could not be paid.
module change_dispenser
    import change_dispenser_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    change_dispenser_if.slave dif,
    output state_t dbg_state
);

    state_t     state;
    money_t     remainder_q;
    logic [7:0] coins_q;
    coin_mask_t sel_q;
    coin_mask_t pick;
    logic       pick_found;

    coin_selector u_coin_selector (
        .remainder  (remainder_q),
        .coin_empty (dif.coin_empty),
        .sel        (pick),
        .found      (pick_found)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            remainder_q <= '0;
            coins_q     <= '0;
            sel_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dif.return_req) begin
                        remainder_q <= dif.return_amount;
                        coins_q     <= '0;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    if (pick_found) begin
                        sel_q <= pick;
                        state <= ISSUE;
                    end else begin
                        state <= DONE;
                    end
                end
                ISSUE: begin
                    // sel_q is frozen here; coin_empty changes only matter at the next SELECT.
                    if (dif.coin_ready) begin
                        remainder_q <= remainder_q - coin_value(sel_q);
                        if (coins_q != 8'hFF) coins_q <= coins_q + 8'd1;
                        sel_q <= '0;
                        state <= SELECT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dif.coin_valid = (state == ISSUE);
    assign dif.coin_sel   = sel_q;
    assign dif.busy       = (state != IDLE);
    assign dif.done       = (state == DONE);
    assign dif.short      = (state == DONE) && (remainder_q != '0);
    assign dif.remainder  = remainder_q;
    assign dif.coins_out  = coins_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin sequences, back-pressure, short payouts and mid-issue reset.
module tb_change_dispenser;
    import change_dispenser_pkg::*;

    logic   clk;
    logic   reset_n;
    state_t dbg_state;

    int n_asserts = 0;
    int n_fail    = 0;
    int done_cnt  = 0;

    logic [kNumCoins-1:0] exp_q[$];
    logic [kNumCoins-1:0] got_q[$];

    change_dispenser_if dif ();

    change_dispenser dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dif       (dif.slave),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted-coin monitor
    always @(posedge clk) begin
        if (dif.coin_valid && dif.coin_ready) got_q.push_back(dif.coin_sel);
        if (dif.done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_request(input money_t amount);
        dif.return_req    = 1'b1;
        dif.return_amount = amount;
        @(negedge clk);
        dif.return_req    = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (dif.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic check_coins(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_coin"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"},     32'(dif.coin_valid), 32'd0);
        check({tag, "_sel"},       32'(dif.coin_sel),   32'd0);
        check({tag, "_busy"},      32'(dif.busy),       32'd0);
        check({tag, "_done"},      32'(dif.done),       32'd0);
        check({tag, "_short"},     32'(dif.short),      32'd0);
        check({tag, "_remainder"}, 32'(dif.remainder),  32'd0);
        check({tag, "_coins_out"}, 32'(dif.coins_out),  32'd0);
        check({tag, "_state"},     32'(dbg_state),      32'(IDLE));
    endtask

    initial begin
        int done_snap;

        reset_n           = 1'b0;
        dif.return_req    = 1'b0;
        dif.return_amount = '0;
        dif.coin_empty    = '0;
        dif.coin_ready    = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_zero("post_release");

        // 1700: 1000, 500, 100, 100 with first-coin latency check
        do_request(money_t'(1700));
        check("lat_busy",  32'(dif.busy),       32'd1);
        check("lat_valid", 32'(dif.coin_valid), 32'd0);
        @(negedge clk);
        check("lat_valid2", 32'(dif.coin_valid), 32'd1);
        check("lat_sel2",   32'(dif.coin_sel),   32'b100);
        wait_done(100);
        check("a1700_short",     32'(dif.short),     32'd0);
        check("a1700_remainder", 32'(dif.remainder), 32'd0);
        check("a1700_coins_out", 32'(dif.coins_out), 32'd4);
        exp_q = '{3'b100, 3'b010, 3'b001, 3'b001};
        check_coins("a1700");
        @(negedge clk);

        // 700 with 500 hopper empty: seven 100 coins
        dif.coin_empty = 3'b010;
        do_request(money_t'(700));
        wait_done(100);
        check("a700_short",     32'(dif.short),     32'd0);
        check("a700_remainder", 32'(dif.remainder), 32'd0);
        check("a700_coins_out", 32'(dif.coins_out), 32'd7);
        for (int i = 0; i < 7; i++) exp_q.push_back(3'b001);
        check_coins("a700");
        dif.coin_empty = '0;
        @(negedge clk);

        // 150: one coin then short with 50 left
        do_request(money_t'(150));
        wait_done(100);
        check("a150_short",     32'(dif.short),     32'd1);
        check("a150_remainder", 32'(dif.remainder), 32'd50);
        check("a150_coins_out", 32'(dif.coins_out), 32'd1);
        exp_q = '{3'b001};
        check_coins("a150");
        @(negedge clk);
        check("a150_hold_rem", 32'(dif.remainder), 32'd50);
        check("a150_short_low", 32'(dif.short),    32'd0);

        // 1000 under back-pressure; hopper flag change must not disturb the offered coin
        dif.coin_ready = 1'b0;
        do_request(money_t'(1000));
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid",     32'(dif.coin_valid), 32'd1);
            check("bp_sel",       32'(dif.coin_sel),   32'b100);
            check("bp_remainder", 32'(dif.remainder),  32'd1000);
            if (k == 2) dif.coin_empty = 3'b100;
            @(negedge clk);
        end
        dif.coin_ready = 1'b1;
        wait_done(100);
        check("bp_remainder_end", 32'(dif.remainder), 32'd0);
        check("bp_coins_out",     32'(dif.coins_out), 32'd1);
        check("bp_short",         32'(dif.short),     32'd0);
        exp_q = '{3'b100};
        check_coins("bp");
        dif.coin_empty = '0;
        @(negedge clk);

        // Zero amount: done two cycles after request; re-request while busy ignored
        do_request(money_t'(0));
        dif.return_req    = 1'b1;
        dif.return_amount = money_t'(5000);
        check("z_busy", 32'(dif.busy), 32'd1);
        check("z_done_early", 32'(dif.done), 32'd0);
        @(negedge clk);
        dif.return_req = 1'b0;
        check("z_done",      32'(dif.done),       32'd1);
        check("z_short",     32'(dif.short),      32'd0);
        check("z_valid",     32'(dif.coin_valid), 32'd0);
        check("z_remainder", 32'(dif.remainder),  32'd0);
        @(negedge clk);
        check("z_idle_busy", 32'(dif.busy),      32'd0);
        check("z_ignored",   32'(dif.remainder), 32'd0);
        check_coins("zero");

        // All hoppers empty with nonzero balance
        dif.coin_empty = 3'b111;
        do_request(money_t'(300));
        wait_done(20);
        check("empty_short",     32'(dif.short),     32'd1);
        check("empty_remainder", 32'(dif.remainder), 32'd300);
        check("empty_coins_out", 32'(dif.coins_out), 32'd0);
        check_coins("empty");
        dif.coin_empty = '0;
        @(negedge clk);

        // Asynchronous reset while a 1500 coin offer is pending
        dif.coin_ready = 1'b0;
        do_request(money_t'(1500));
        @(negedge clk);
        check("rst_pre_valid", 32'(dif.coin_valid), 32'd1);
        check("rst_pre_sel",   32'(dif.coin_sel),   32'b100);
        done_snap = done_cnt;
        #2 reset_n = 1'b0;
        #1 check_idle_zero("async_rst");
        @(negedge clk);
        reset_n        = 1'b1;
        dif.coin_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_done", 32'(done_cnt), 32'(done_snap));
        check_idle_zero("rst_after");
        check_coins("rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
